// File: rtl/capture_pkg.sv
// Shared constants and FSM encoding for the capture write arbiter.
package capture_pkg;

    // Fixed AXI write-burst shape: one 64-byte INCR beat per transaction.
    localparam logic [7:0] AWLEN_SINGLE = 8'd0;
    localparam logic [2:0] AWSIZE_64B   = 3'd6;
    localparam logic [1:0] BURST_INCR   = 2'd1;
    localparam logic [1:0] RESP_OKAY    = 2'd0;

    // Width of the per-port outstanding counters (MAX_OUTSTANDING <= 15).
    localparam int OUTST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } wr_state_e;

    // Saturating increment for the 16-bit error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/capture_wr_arb_rr_arbiter.sv
// Round-robin request-to-grant: searches from the port after the last
// granted one and remembers the winner whenever a grant is taken.
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 advance_i,
    output logic                 grant_valid_o,
    output logic [IDX_W-1:0]     grant_idx_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W:0]   cand_s;
    logic             grant_valid_s;
    logic [IDX_W-1:0] grant_idx_s;

    // First requesting port at or after last_q+1, wrapping modulo NUM_PORTS.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {IDX_W{1'b0}};
        cand_s        = {(IDX_W+1){1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_s = {1'b0, last_q} + (IDX_W+1)'(k + 1);
            if (cand_s >= (IDX_W+1)'(NUM_PORTS)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_PORTS);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid_s && req_i[cand_s[IDX_W-1:0]]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Pointer register; reset value makes port 0 the first candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDX_W'(NUM_PORTS - 1);
        end else if (advance_i && grant_valid_s) begin
            last_q <= grant_idx_s;
        end else begin
            last_q <= last_q;
        end
    end

    assign grant_valid_o = grant_valid_s;
    assign grant_idx_o   = grant_idx_s;

endmodule

// File: rtl/capture_wr_arb.sv
// Shares one AXI-MM write port among NUM_PORTS capture engines. One request
// is latched at a time and played out as AW then W; B responses are routed
// back to the issuing engine by ID through a one-entry holding register.
module capture_wr_arb
    import capture_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int STRB_WIDTH      = 64,
    parameter int ID_WIDTH        = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_awaddr,
    input  logic [NUM_PORTS-1:0]            s_awvalid,
    output logic [NUM_PORTS-1:0]            s_awready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0] s_wstrb,
    input  logic [NUM_PORTS-1:0]            s_wvalid,
    output logic [NUM_PORTS-1:0]            s_wready,
    output logic [1:0]                      s_bresp,
    output logic [NUM_PORTS-1:0]            s_bvalid,
    input  logic [NUM_PORTS-1:0]            s_bready,
    output logic [ID_WIDTH-1:0]             m_awid,
    output logic [ADDR_WIDTH-1:0]           m_awaddr,
    output logic [7:0]                      m_awlen,
    output logic [2:0]                      m_awsize,
    output logic [1:0]                      m_awburst,
    output logic                            m_awvalid,
    input  logic                            m_awready,
    output logic [DATA_WIDTH-1:0]           m_wdata,
    output logic [STRB_WIDTH-1:0]           m_wstrb,
    output logic                            m_wlast,
    output logic                            m_wvalid,
    input  logic                            m_wready,
    input  logic [ID_WIDTH-1:0]             m_bid,
    input  logic [1:0]                      m_bresp,
    input  logic                            m_bvalid,
    output logic                            m_bready,
    output logic                            busy,
    output logic [15:0]                     err_count
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    wr_state_e              state_q;
    logic [ADDR_WIDTH-1:0]  awaddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]  wstrb_q;
    logic [ID_WIDTH-1:0]    awid_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic [OUTST_W-1:0]     outst_q [NUM_PORTS];
    logic                   b_hold_q;
    logic [IDX_W-1:0]       b_id_q;
    logic [1:0]             b_resp_q;
    logic [15:0]            err_q;

    logic [NUM_PORTS-1:0]   elig_s;
    logic                   grant_valid_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   grant_take_s;
    logic [ADDR_WIDTH-1:0]  sel_addr_s;
    logic [DATA_WIDTH-1:0]  sel_data_s;
    logic [STRB_WIDTH-1:0]  sel_strb_s;
    logic [NUM_PORTS-1:0]   grant_oh_s;
    logic [NUM_PORTS-1:0]   inc_s;
    logic [NUM_PORTS-1:0]   dec_s;
    logic [NUM_PORTS-1:0]   bvalid_s;
    logic                   b_hs_s;
    logic                   bid_ok_s;
    logic                   b_err_s;

    assign grant_take_s = (state_q == ST_IDLE) && grant_valid_s;
    assign b_hs_s       = m_bvalid && !b_hold_q;
    assign bid_ok_s     = (m_bid < ID_WIDTH'(NUM_PORTS));
    assign b_err_s      = b_hs_s && (!bid_ok_s || (m_bresp != RESP_OKAY));

    // A port competes only with both halves of its write present and credit left.
    always_comb begin
        elig_s = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig_s[i] = s_awvalid[i] & s_wvalid[i]
                      & (outst_q[i] < OUTST_W'(MAX_OUTSTANDING));
        end
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .clk           (clk),
        .rst           (rst),
        .req_i         (elig_s),
        .advance_i     (state_q == ST_IDLE),
        .grant_valid_o (grant_valid_s),
        .grant_idx_o   (grant_idx_s)
    );

    // AND-OR mux of the granted port's address, data and strobes.
    always_comb begin
        sel_addr_s = {ADDR_WIDTH{1'b0}};
        sel_data_s = {DATA_WIDTH{1'b0}};
        sel_strb_s = {STRB_WIDTH{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_addr_s = sel_addr_s | (s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH]
                       & {ADDR_WIDTH{grant_idx_s == IDX_W'(i)}});
            sel_data_s = sel_data_s | (s_wdata[i*DATA_WIDTH +: DATA_WIDTH]
                       & {DATA_WIDTH{grant_idx_s == IDX_W'(i)}});
            sel_strb_s = sel_strb_s | (s_wstrb[i*STRB_WIDTH +: STRB_WIDTH]
                       & {STRB_WIDTH{grant_idx_s == IDX_W'(i)}});
        end
    end

    // One-hot grant strobe, credit increments/decrements and B routing.
    always_comb begin
        grant_oh_s = {NUM_PORTS{1'b0}};
        inc_s      = {NUM_PORTS{1'b0}};
        dec_s      = {NUM_PORTS{1'b0}};
        bvalid_s   = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_oh_s[i] = grant_take_s && (grant_idx_s == IDX_W'(i));
            inc_s[i]      = grant_oh_s[i];
            dec_s[i]      = b_hs_s && bid_ok_s
                          && (m_bid[IDX_W-1:0] == IDX_W'(i))
                          && (outst_q[i] != {OUTST_W{1'b0}});
            bvalid_s[i]   = b_hold_q && (b_id_q == IDX_W'(i));
        end
    end

    // Write FSM: latch on grant, present AW, then W, back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wstrb_q   <= {STRB_WIDTH{1'b0}};
            awid_q    <= {ID_WIDTH{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        awaddr_q  <= sel_addr_s;
                        wdata_q   <= sel_data_s;
                        wstrb_q   <= sel_strb_s;
                        awid_q    <= ID_WIDTH'(grant_idx_s);
                        awvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (m_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end else begin
                        state_q   <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (m_wready) begin
                        wvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q  <= ST_DATA;
                    end
                end
                default: begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-port outstanding credit; simultaneous inc/dec cancel, never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                outst_q[i] <= {OUTST_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (inc_s[i] && !dec_s[i]) begin
                    outst_q[i] <= outst_q[i] + OUTST_W'(1);
                end else if (dec_s[i] && !inc_s[i]) begin
                    outst_q[i] <= outst_q[i] - OUTST_W'(1);
                end else begin
                    outst_q[i] <= outst_q[i];
                end
            end
        end
    end

    // B holding register: accept when empty, release on the target's bready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_hold_q <= 1'b0;
            b_id_q   <= {IDX_W{1'b0}};
            b_resp_q <= 2'd0;
        end else if (b_hold_q) begin
            if (s_bready[b_id_q]) begin
                b_hold_q <= 1'b0;
            end else begin
                b_hold_q <= 1'b1;
            end
        end else if (m_bvalid && bid_ok_s) begin
            b_hold_q <= 1'b1;
            b_id_q   <= m_bid[IDX_W-1:0];
            b_resp_q <= m_bresp;
        end else begin
            b_hold_q <= 1'b0;
        end
    end

    // Saturating count of error or unroutable responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 16'd0;
        end else if (b_err_s) begin
            err_q <= sat_inc16(err_q);
        end else begin
            err_q <= err_q;
        end
    end

    assign s_awready = grant_oh_s;
    assign s_wready  = grant_oh_s;
    assign s_bvalid  = bvalid_s;
    assign s_bresp   = b_resp_q;
    assign m_awid    = awid_q;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = AWLEN_SINGLE;
    assign m_awsize  = AWSIZE_64B;
    assign m_awburst = BURST_INCR;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_wlast   = wvalid_q;
    assign m_bready  = !b_hold_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_count = err_q;

endmodule
